// File: rtl/p2_master.sv
// P2 bus master: turns a single host request into a SETUP/STROBE/DONE bus cycle,
// with responder wait extension and a timeout that aborts the cycle as a bus error.
module p2_master #(
  parameter int STROBE  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  be,
  input  logic [22:0] haddr,
  input  logic [15:0] hwdata,
  output logic        ack,
  output logic        berr,
  output logic        busy,
  output logic [15:0] hrdata,
  output logic [22:0] addr,
  output logic        decode,
  output logic        wel_n,
  output logic        weu_n,
  output logic        rw_n,
  output logic        go_n,
  input  logic        wait_n,
  output logic [15:0] p2_dout,
  input  logic [15:0] p2_din
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STROBE - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [22:0]   addr_q, addr_d;
  logic [15:0]   dout_q, dout_d;
  logic [15:0]   hrdata_q, hrdata_d;
  logic          we_q, we_d;
  logic [1:0]    be_q, be_d;
  logic          err_q, err_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      dout_q   <= '0;
      hrdata_q <= '0;
      we_q     <= 1'b0;
      be_q     <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      hrdata_q <= hrdata_d;
      we_q     <= we_d;
      be_q     <= be_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    hrdata_d = hrdata_q;
    we_d     = we_q;
    be_d     = be_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d = haddr;
          dout_d = hwdata;
          we_d   = we;
          be_d   = be;
          err_d  = 1'b0;
          // A write with no byte enabled has nothing to put on the bus.
          if (we && be == 2'b00) state_d = ST_DONE;
          else                   state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
        // Only an explicit 0 on wait_n extends; X/Z fall through as released.
        if (cnt_q >= STB_LAST) begin
          if (wait_n == 1'b0) begin
            if (cnt_q >= TO_LAST) begin
              state_d = ST_DONE;
              err_d   = 1'b1;
              if (!we_q) hrdata_d = 16'hFFFF;
            end
          end else begin
            state_d = ST_DONE;
            if (!we_q) hrdata_d = p2_din;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  logic on_bus;
  assign on_bus  = (state_q == ST_SETUP) || (state_q == ST_STROBE);

  assign busy    = (state_q != ST_IDLE);
  assign decode  = on_bus;
  assign go_n    = (state_q != ST_STROBE);
  assign rw_n    = on_bus ? ~we_q : 1'b1;
  assign wel_n   = (on_bus && we_q) ? ~be_q[0] : 1'b1;
  assign weu_n   = (on_bus && we_q) ? ~be_q[1] : 1'b1;
  assign ack     = (state_q == ST_DONE) && !err_q;
  assign berr    = (state_q == ST_DONE) && err_q;
  assign addr    = addr_q;
  assign p2_dout = dout_q;
  assign hrdata  = hrdata_q;

endmodule

// File: tb/tb_p2_master.sv
// Directed bench for p2_master (STROBE=2, TIMEOUT=8) against a small word-wide
// responder with byte enables and a programmable wait extension.
module tb_p2_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  be = 2'b00;
  logic [22:0] haddr = '0;
  logic [15:0] hwdata = '0;
  logic        ack, berr, busy, decode, wel_n, weu_n, rw_n, go_n, wait_n;
  logic [15:0] hrdata, p2_dout, p2_din;
  logic [22:0] addr;

  always #5 clk = ~clk;

  p2_master #(.STROBE(2), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .be(be),
    .haddr(haddr), .hwdata(hwdata), .ack(ack), .berr(berr), .busy(busy),
    .hrdata(hrdata), .addr(addr), .decode(decode), .wel_n(wel_n),
    .weu_n(weu_n), .rw_n(rw_n), .go_n(go_n), .wait_n(wait_n),
    .p2_dout(p2_dout), .p2_din(p2_din)
  );

  // Responder: holds wait_n low for wait_len clocks after go_n falls.
  logic [15:0] mem [256];
  int          low_cnt = 0;
  int          wait_len = 0;

  assign wait_n = !(go_n == 1'b0 && low_cnt < wait_len);
  assign p2_din = mem[addr[7:0]];

  always @(posedge clk) begin
    low_cnt <= go_n ? 0 : low_cnt + 1;
    if (!go_n && !rw_n) begin
      if (!wel_n) mem[addr[7:0]][7:0]  <= p2_dout[7:0];
      if (!weu_n) mem[addr[7:0]][15:8] <= p2_dout[15:8];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  int          lat, go_low, ack_cnt, berr_cnt;
  logic        wel_seen, weu_seen, rw_seen, dec_seen, both_seen, k1_go, k1_dec;
  logic [22:0] addr_k2;

  task automatic run(input logic w, input logic [1:0] b, input logic [22:0] a,
                     input logic [15:0] d, input int wl, input logic hold);
    wait_len = wl;
    lat = 0; go_low = 0; ack_cnt = 0; berr_cnt = 0;
    wel_seen = 0; weu_seen = 0; rw_seen = 0; dec_seen = 0; both_seen = 0;
    k1_go = 0; k1_dec = 0; addr_k2 = '0;
    @(negedge clk);
    req = 1'b1; we = w; be = b; haddr = a; hwdata = d;
    @(posedge clk);
    #1;
    if (!hold) req = 1'b0;
    haddr = 23'h7FFFFF;
    hwdata = 16'h0000;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!go_n)  go_low++;
      if (!wel_n) wel_seen = 1'b1;
      if (!weu_n) weu_seen = 1'b1;
      if (!rw_n)  rw_seen = 1'b1;
      if (decode) dec_seen = 1'b1;
      if (k == 1) begin k1_go = go_n; k1_dec = decode; end
      if (k == 2) addr_k2 = addr;
      if (ack)  ack_cnt++;
      if (berr) berr_cnt++;
      if (ack && berr) both_seen = 1'b1;
      if ((ack || berr) && lat == 0) begin
        lat = k;
        req = 1'b0;
      end
      if (lat != 0 && k >= lat + 3) break;
    end
    $display("txn we=%0b be=%b addr=0x%0h wait=%0d: lat=%0d go_low=%0d ack=%0d berr=%0d hrdata=0x%0h",
             w, b, a, wl, lat, go_low, ack_cnt, berr_cnt, hrdata);
  endtask

  int glitch;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_go_n", go_n, 1);
    check("rst_busy", busy, 0);
    check("rst_ack_berr", {ack, berr}, 0);
    check("rst_decode", decode, 0);
    check("rst_we_rw", {wel_n, weu_n, rw_n}, 3'b111);
    check("rst_addr", addr, 0);
    check("rst_dout", p2_dout, 0);
    check("rst_hrdata", hrdata, 0);
    reset_n = 1'b1;

    run(1'b1, 2'b11, 23'h00123, 16'hBEEF, 0, 1'b0);
    check("wr_lat", lat, 4);
    check("wr_go_low", go_low, 2);
    check("wr_setup", {k1_go, k1_dec}, 2'b11);
    check("wr_addr", addr_k2, 23'h00123);
    check("wr_strobes", {wel_seen, weu_seen, rw_seen}, 3'b111);
    check("wr_acks", {ack_cnt[3:0], berr_cnt[3:0]}, 8'h10);
    check("wr_mem", mem[8'h23], 16'hBEEF);

    run(1'b0, 2'b00, 23'h00123, 16'h0000, 0, 1'b0);
    check("rd_lat", lat, 4);
    check("rd_strobes", {wel_seen, weu_seen, rw_seen}, 3'b000);
    check("rd_data", hrdata, 16'hBEEF);

    run(1'b1, 2'b11, 23'h00045, 16'h1234, 0, 1'b0);
    run(1'b0, 2'b00, 23'h00045, 16'h0000, 5, 1'b0);
    check("wait_go_low", go_low, 6);
    check("wait_lat", lat, 8);
    check("wait_acks", {ack_cnt[3:0], berr_cnt[3:0]}, 8'h10);
    check("wait_data", hrdata, 16'h1234);

    run(1'b0, 2'b00, 23'h00045, 16'h0000, 1000, 1'b0);
    check("to_go_low", go_low, 8);
    check("to_lat", lat, 10);
    check("to_acks", {ack_cnt[3:0], berr_cnt[3:0]}, 8'h01);
    check("to_data", hrdata, 16'hFFFF);
    check("to_both", both_seen, 0);

    run(1'b1, 2'b00, 23'h00045, 16'h5A5A, 0, 1'b0);
    check("be0_lat", lat, 1);
    check("be0_go_low", go_low, 0);
    check("be0_decode", dec_seen, 0);
    check("be0_acks", {ack_cnt[3:0], berr_cnt[3:0]}, 8'h10);
    check("be0_mem", mem[8'h45], 16'h1234);

    run(1'b1, 2'b01, 23'h00045, 16'hAAAA, 0, 1'b0);
    check("be1_strobes", {wel_seen, weu_seen}, 2'b10);
    run(1'b0, 2'b00, 23'h00045, 16'h0000, 0, 1'b0);
    check("be1_data", hrdata, 16'h12AA);

    // req held high through the whole cycle with haddr changing must not re-trigger
    run(1'b1, 2'b11, 23'h00067, 16'h5555, 0, 1'b1);
    check("hold_addr", addr_k2, 23'h00067);
    check("hold_lat", lat, 4);
    check("hold_acks", ack_cnt, 1);
    check("hold_idle", busy, 0);
    check("hold_mem", mem[8'h67], 16'h5555);

    // reset pulse during the second STROBE clock of a read
    wait_len = 0;
    glitch = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; be = 2'b00; haddr = 23'h00123;
    @(posedge clk);
    #1 req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (ack || berr) glitch++;
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rstmid_go_n", go_n, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_hrdata", hrdata, 0);
    for (int k = 0; k < 3; k++) begin
      if (ack || berr) glitch++;
      @(negedge clk);
    end
    check("rstmid_no_pulse", glitch, 0);
    $display("txn reset mid-strobe: pulses=%0d", glitch);
    run(1'b0, 2'b00, 23'h00123, 16'h0000, 0, 1'b0);
    check("rstmid_rd_lat", lat, 4);
    check("rstmid_rd_data", hrdata, 16'hBEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
